// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package mem_loader_pkg;

  typedef enum logic [3:0] {
    S_SYNC,
    S_AH,
    S_AL,
    S_LH,
    S_LL,
    S_DATA,
    S_CHK,
    S_HOLD,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         HDR_LEN       = 5;

endpackage

// File: rtl/mem_loader.sv
// Boot loader: parses framed load records from a byte stream, writes payload
// into memory and holds the CPU in reset until the end-of-image record.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         ADDR_W      = 16,
  parameter int         HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES);

  state_t            state;
  state_t            state_nxt;
  logic              acc;
  logic              ready_nxt;
  logic [15:0]       len_full;
  logic [7:0]        addr_hi_p0;
  logic [7:0]        len_hi_p0;
  logic [7:0]        sum_p0;
  logic [7:0]        hold_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [15:0]       remain_p0;

  function automatic logic [7:0] csum_add(input logic [7:0] s, input logic [7:0] b);
    return s + b;
  endfunction

  function automatic logic takes_bytes(input state_t s);
    return (s != S_HOLD) && (s != S_DONE) && (s != S_ERR);
  endfunction

  assign acc      = in_valid && in_ready;
  assign len_full = {len_hi_p0, in_data};

  always_comb begin
    state_nxt = state;
    case (state)
      S_SYNC: if (acc && (in_data == SYNC_BYTE)) state_nxt = S_AH;
      S_AH:   if (acc) state_nxt = S_AL;
      S_AL:   if (acc) state_nxt = S_LH;
      S_LH:   if (acc) state_nxt = S_LL;
      S_LL:   if (acc) state_nxt = (len_full == 16'd0) ? S_HOLD : S_DATA;
      S_DATA: if (acc && (remain_p0 == 16'd1)) state_nxt = S_CHK;
      S_CHK:  if (acc) state_nxt = (in_data == sum_p0) ? S_SYNC : S_ERR;
      S_HOLD: if (hold_p0 == 8'd0) state_nxt = S_DONE;
      S_DONE: state_nxt = S_DONE;
      S_ERR:  state_nxt = S_ERR;
      default: state_nxt = S_SYNC;
    endcase
    ready_nxt = takes_bytes(state_nxt);
  end

  // stage p0: control state and the registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_SYNC;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= ready_nxt;
      mem_we   <= (state == S_DATA) && acc;
      if ((state == S_DATA) && acc) begin
        mem_addr  <= addr_p0;
        mem_wdata <= in_data;
      end
    end
  end

  // Header fields, payload counter, checksum and hold counter carry no reset:
  // each is loaded before the state that consumes it is entered.
  always_ff @(posedge clk) begin
    case (state)
      S_AH: if (acc) addr_hi_p0 <= in_data;
      S_AL: if (acc) addr_p0 <= ADDR_W'({addr_hi_p0, in_data});
      S_LH: if (acc) len_hi_p0 <= in_data;
      S_LL: begin
        if (acc) begin
          remain_p0 <= len_full;
          sum_p0    <= 8'd0;
          hold_p0   <= HOLD_INIT;
        end
      end
      S_DATA: begin
        if (acc) begin
          addr_p0   <= addr_p0 + ADDR_W'(1);
          sum_p0    <= csum_add(sum_p0, in_data);
          remain_p0 <= remain_p0 - 16'd1;
        end
      end
      S_HOLD: if (hold_p0 != 8'd0) hold_p0 <= hold_p0 - 8'd1;
      default: ;
    endcase
  end

  assign cpu_rst = (state != S_DONE);
  assign done    = (state == S_DONE);
  assign err     = (state == S_ERR);

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: a frame-level write model plus a per-cycle
// write-port comparator, with hand-computed timing and memory expectations.
module tb_mem_loader;
  import mem_loader_pkg::*;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int we_count = 0;

  wr_t         exp_q[$];
  logic [15:0] wr_log[$];
  logic [7:0]  exp_mem[65536];
  bit          exp_wr[65536];
  logic [7:0]  dut_mem[65536];
  bit          dut_wr[65536];

  mem_loader #(
    .SYNC_BYTE  (8'hA5),
    .ADDR_W     (16),
    .HOLD_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Every write the DUT issues must be the next one the model expects.
  always @(negedge clk) begin
    if (mem_we) begin
      we_count++;
      wr_log.push_back(mem_addr);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected actual=%h:%h required=no_write", mem_addr, mem_wdata);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        if ((mem_addr !== w.addr) || (mem_wdata !== w.data)) begin
          errors++;
          $display("FAIL write_port actual=%h:%h required=%h:%h", mem_addr, mem_wdata, w.addr, w.data);
        end
      end
      dut_mem[mem_addr] = mem_wdata;
      dut_wr[mem_addr]  = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    exp_q.delete();
    wr_log.delete();
    for (int i = 0; i < 65536; i++) begin
      exp_mem[i] = 8'h00;
      exp_wr[i]  = 1'b0;
      dut_mem[i] = 8'h00;
      dut_wr[i]  = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);
  endtask

  // Presents one byte from a negedge and returns on the negedge after it is accepted.
  task automatic send_b(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    while ((gap > 0) && (n < 8) && ($urandom_range(99) < gap)) begin
      in_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && (n < 64)) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=not_ready required=ready byte=%h", b);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] addr, input logic [15:0] len, input int gap);
    logic [7:0] hdr[HDR_LEN];
    hdr[0] = SYNC_BYTE_DEF;
    hdr[1] = addr[15:8];
    hdr[2] = addr[7:0];
    hdr[3] = len[15:8];
    hdr[4] = len[7:0];
    for (int i = 0; i < HDR_LEN; i++) send_b(hdr[i], gap);
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
    exp_mem[a] = d;
    exp_wr[a]  = 1'b1;
  endtask

  // chk_force < 0 sends the true checksum; otherwise that byte is sent instead.
  task automatic send_frame(input logic [15:0] addr, input bq_t pl, input int chk_force, input int gap);
    int s;
    s = 0;
    send_hdr(addr, 16'(pl.size()), gap);
    for (int i = 0; i < pl.size(); i++) begin
      expect_wr(16'((int'(addr) + i) % 65536), pl[i]);
      s = (s + int'(pl[i])) % 256;
      send_b(pl[i], gap);
    end
    send_b((chk_force < 0) ? 8'(s) : 8'(chk_force), gap);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    chk(name, done, 1);
    chk({name, "_cpu_rst"}, cpu_rst, 0);
  endtask

  bq_t pl;
  bq_t pl2;
  int  base_we;

  initial begin
    // Scenario 1: basic frame, then end record with exact hold timing.
    do_reset();
    pl = '{8'h13, 8'h00, 8'h00, 8'h00};
    send_frame(16'h0000, pl, -1, 0);
    send_hdr(16'h0000, 16'h0000, 0);
    chk("end_ready_k0", in_ready, 0);
    chk("end_cpu_rst_k0", cpu_rst, 1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("done_k%0d", k), done, (k == 5) ? 1 : 0);
      chk($sformatf("cpu_rst_k%0d", k), cpu_rst, (k == 5) ? 0 : 1);
    end
    chk("s1_mem0", dut_mem[0], 8'h13);
    chk("s1_mem1", dut_mem[1], 8'h00);
    chk("s1_wr3", dut_wr[3], 1);
    chk("s1_we_count", we_count, 4);
    chk("s1_queue_empty", exp_q.size(), 0);

    // Scenario 2: address wrap from 0xFFFE.
    do_reset();
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(16'hFFFE, pl, 8'h0A, 0);
    @(negedge clk);
    chk("wrap_log_len", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      chk("wrap_addr0", wr_log[0], 16'hFFFE);
      chk("wrap_addr1", wr_log[1], 16'hFFFF);
      chk("wrap_addr2", wr_log[2], 16'h0000);
      chk("wrap_addr3", wr_log[3], 16'h0001);
    end
    chk("wrap_mem_0001", dut_mem[16'h0001], 8'h04);
    chk("wrap_no_err", err, 0);
    chk("wrap_ready", in_ready, 1);

    // Scenario 3: checksum mismatch is terminal.
    do_reset();
    pl = '{8'h13, 8'h00, 8'h00, 8'h00};
    send_frame(16'h0000, pl, 8'h18, 0);
    chk("bad_err", err, 1);
    chk("bad_ready", in_ready, 0);
    for (int k = 0; k < 100; k++) begin
      in_valid = 1'b1;
      in_data  = SYNC_BYTE_DEF;
      @(negedge clk);
      chk("bad_err_hold", err, 1);
      chk("bad_ready_hold", in_ready, 0);
      chk("bad_cpu_rst_hold", cpu_rst, 1);
    end
    in_valid = 1'b0;
    chk("bad_mem0", dut_mem[0], 8'h13);
    chk("bad_wr3", dut_wr[3], 1);
    chk("bad_queue_empty", exp_q.size(), 0);

    // Scenario 4: garbage before sync is discarded.
    do_reset();
    base_we = we_count;
    send_b(8'h00, 0);
    send_b(8'hFF, 0);
    send_b(8'h5A, 0);
    @(negedge clk);
    chk("garbage_no_write", we_count - base_we, 0);
    pl = '{8'hAA, 8'h55};
    send_frame(16'h0100, pl, -1, 0);
    send_hdr(16'h0000, 16'h0000, 0);
    wait_done("garbage_done");
    chk("garbage_mem100", dut_mem[16'h0100], 8'hAA);
    chk("garbage_mem101", dut_mem[16'h0101], 8'h55);

    // Scenario 5: three frames with random idle gaps, overlapping writes.
    do_reset();
    base_we = we_count;
    pl.delete();
    for (int i = 0; i < 5; i++) pl.push_back(8'($urandom));
    send_frame(16'h1000, pl, -1, 30);
    pl2.delete();
    for (int i = 0; i < 4; i++) pl2.push_back(8'($urandom));
    send_frame(16'h1003, pl2, -1, 30);
    pl.delete();
    for (int i = 0; i < 6; i++) pl.push_back(8'($urandom));
    send_frame(16'h2000, pl, -1, 30);
    send_hdr(16'h0000, 16'h0000, 30);
    wait_done("gaps_done");
    chk("gaps_we_count", we_count - base_we, 15);
    chk("gaps_last_wins_model", exp_mem[16'h1003], pl2[0]);
    for (int a = 16'h1000; a < 16'h1007; a++)
      chk($sformatf("gaps_mem_%h", a), dut_mem[a], exp_mem[a]);
    for (int a = 16'h2000; a < 16'h2006; a++)
      chk($sformatf("gaps_mem_%h", a), dut_mem[a], exp_mem[a]);
    chk("gaps_queue_empty", exp_q.size(), 0);

    // Scenario 6: reset at the third payload byte, then a fresh image.
    do_reset();
    base_we = we_count;
    send_hdr(16'h0200, 16'h0004, 0);
    expect_wr(16'h0200, 8'h11);
    send_b(8'h11, 0);
    expect_wr(16'h0201, 8'h22);
    send_b(8'h22, 0);
    in_valid = 1'b1;
    in_data  = 8'h33;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    chk("abort_we_drop", mem_we, 0);
    chk("abort_ready", in_ready, 0);
    repeat (3) @(negedge clk);
    chk("abort_writes", we_count - base_we, 2);
    chk("abort_kept_0200", dut_mem[16'h0200], 8'h11);
    pl = '{8'h77, 8'h88};
    send_frame(16'h0200, pl, -1, 0);
    send_hdr(16'h0000, 16'h0000, 0);
    wait_done("abort_done");
    chk("abort_mem200", dut_mem[16'h0200], 8'h77);
    chk("abort_mem201", dut_mem[16'h0201], 8'h88);
    chk("abort_no_202", dut_wr[16'h0202], 0);
    chk("abort_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
